// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: widths, reset vector and the fetch FSM state type.
package inst_fetch_pkg;

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_INST = 32;

    localparam logic [W_ADDR-1:0] RESET_VECTOR = 32'hbfc0_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer: parks returned data while the decode stage is holding.
module fetch_buf
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [W_INST-1:0] data_i,
    output logic [W_INST-1:0] data_o
);

    logic [W_INST-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sram-like bus master with one outstanding read, flush
// cancellation, downstream hold buffering and misaligned-PC exception reporting.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] pc_addr,
    input  logic              flush,
    input  logic              hold,
    output logic              inst_req,
    output logic [W_ADDR-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [W_INST-1:0] inst_rdata,
    output logic [W_INST-1:0] if_inst,
    output logic              if_valid,
    output logic              if_adel,
    output logic              if_stall
);

    fetch_state_t      state_q, state_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic              drop_q, drop_d;
    logic              buf_load, buf_clr, complete;
    logic [W_INST-1:0] buf_data;

    fetch_buf u_fetch_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (buf_load),
        .clr_i  (buf_clr),
        .data_i (inst_rdata),
        .data_o (buf_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    // Next state and bus/pipeline outputs; flush always wins over completion.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        inst_req  = 1'b0;
        inst_addr = addr_q;
        if_inst   = '0;
        if_valid  = 1'b0;
        if_adel   = 1'b0;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
        complete  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (!flush) begin
                        if (pc_addr[1:0] != 2'b00) begin
                            if_adel = 1'b1;
                            if (!hold) begin
                                complete = 1'b1;
                                if_valid = 1'b1;
                            end
                        end else begin
                            inst_req  = 1'b1;
                            inst_addr = pc_addr;
                            addr_d    = pc_addr;
                            drop_d    = 1'b0;
                            state_d   = inst_addr_ok ? WAIT : REQ;
                        end
                    end
                end
                REQ: begin
                    // The request cannot be withdrawn; a flush only marks the reply for discard.
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        state_d = (drop_q || flush) ? DROP : WAIT;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = drop_q || flush;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (flush) begin
                            state_d = IDLE;
                        end else if (!hold) begin
                            complete = 1'b1;
                            if_valid = 1'b1;
                            if_inst  = inst_rdata;
                            state_d  = IDLE;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end else if (flush) begin
                        state_d = DROP;
                    end
                end
                HOLD: begin
                    if_inst = buf_data;
                    if (flush) begin
                        buf_clr = 1'b1;
                        state_d = IDLE;
                    end else if (!hold) begin
                        complete = 1'b1;
                        if_valid = 1'b1;
                        state_d  = IDLE;
                    end
                end
                DROP: begin
                    if (inst_data_ok) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if_stall = !complete;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// against a PC/bus reference model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        flush, hold;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_inst;
    logic        if_valid, if_adel, if_stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .flush        (flush),
        .hold         (hold),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .if_adel      (if_adel),
        .if_stall     (if_stall)
    );

    // Memory contents seen by the bench's bus model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic idle_inputs();
        flush        = 1'b0;
        hold         = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_addr = RESET_VECTOR;
        idle_inputs();
        repeat (2) @(negedge clk);
        @(negedge clk);
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; pc_addr = 32'hbfc0_0002; inst_rdata = 32'h1234_5678;
        #1;
        n_total++; if (inst_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", inst_req); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", if_valid); else n_pass++;
        n_total++; if (if_adel !== 1'b0) $display("FAIL rst_adel: got %b exp 0", if_adel); else n_pass++;
        n_total++; if (if_inst !== 32'h0) $display("FAIL rst_inst: got %h exp 0", if_inst); else n_pass++;
        n_total++; if (if_stall !== 1'b1) $display("FAIL rst_stall: got %b exp 1", if_stall); else n_pass++;
        @(negedge clk);
        idle_inputs();
        pc_addr = RESET_VECTOR;
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            pc = RESET_VECTOR + 32'(4 * i);
            @(negedge clk);
            rst = 1'b0; pc_addr = pc; inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
            #1;
            n_total++; if ({inst_req, inst_addr} !== {1'b1, pc}) $display("FAIL zw_issue%0d: got %b/%h exp 1/%h", i, inst_req, inst_addr, pc); else n_pass++;
            n_total++; if ({if_valid, if_stall} !== 2'b01) $display("FAIL zw_issue_flags%0d: got %b%b exp 01", i, if_valid, if_stall); else n_pass++;
            @(negedge clk);
            inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001 + 32'(i);
            #1;
            n_total++; if ({if_valid, if_stall} !== 2'b10) $display("FAIL zw_done_flags%0d: got %b%b exp 10", i, if_valid, if_stall); else n_pass++;
            n_total++; if (if_inst !== 32'h2402_0001 + 32'(i)) $display("FAIL zw_inst%0d: got %h exp %h", i, if_inst, 32'h2402_0001 + 32'(i)); else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_slow_bus();
        logic [31:0] pc;
        int nvalid;
        pc = 32'hbfc0_0100;
        nvalid = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            pc_addr = pc; hold = 1'b0;
            inst_addr_ok = (c == 3); inst_data_ok = (c == 6);
            inst_rdata = (c == 6) ? 32'h1122_3344 : 32'hffff_ffff;
            #1;
            if (c <= 3) begin
                n_total++; if ({inst_req, inst_addr} !== {1'b1, pc}) $display("FAIL slow_req%0d: got %b/%h exp 1/%h", c, inst_req, inst_addr, pc); else n_pass++;
            end else begin
                n_total++; if (inst_req !== 1'b0) $display("FAIL slow_noreq%0d: got %b exp 0", c, inst_req); else n_pass++;
            end
            if (c < 6) begin
                n_total++; if (if_stall !== 1'b1) $display("FAIL slow_stall%0d: got %b exp 1", c, if_stall); else n_pass++;
            end
            if (if_valid === 1'b1) nvalid++;
        end
        n_total++; if (if_inst !== 32'h1122_3344) $display("FAIL slow_inst: got %h exp 11223344", if_inst); else n_pass++;
        n_total++; if (nvalid != 1) $display("FAIL slow_valid_count: got %0d exp 1", nvalid); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_hold();
        pc_addr = 32'hbfc0_0200; inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c43_0004; hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                inst_data_ok = 1'b0; inst_rdata = $urandom();
            end
            #1;
            n_total++; if ({if_valid, if_stall} !== 2'b01) $display("FAIL hold_wait%0d: got %b%b exp 01", c, if_valid, if_stall); else n_pass++;
        end
        @(negedge clk);
        hold = 1'b0; inst_rdata = 32'h0bad_0bad;
        #1;
        n_total++; if ({if_valid, if_inst} !== {1'b1, 32'h8c43_0004}) $display("FAIL hold_release: got %b/%h exp 1/8c430004", if_valid, if_inst); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush_req();
        pc_addr = 32'hbfc0_0300;
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc0_0300}) $display("FAIL fr_issue: got %b/%h exp 1/bfc00300", inst_req, inst_addr); else n_pass++;
        @(negedge clk);
        flush = 1'b1; pc_addr = 32'hbfc0_0380;
        #1;
        n_total++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'hbfc0_0300, 1'b0}) $display("FAIL fr_keep_req: got %b/%h/%b exp 1/bfc00300/0", inst_req, inst_addr, if_valid); else n_pass++;
        @(negedge clk);
        flush = 1'b0; inst_addr_ok = 1'b1;
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc0_0300}) $display("FAIL fr_accept: got %b/%h exp 1/bfc00300", inst_req, inst_addr); else n_pass++;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        #1;
        n_total++; if ({inst_req, if_valid} !== 2'b00) $display("FAIL fr_drop: got %b%b exp 00", inst_req, if_valid); else n_pass++;
        @(negedge clk);
        inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc0_0380}) $display("FAIL fr_reissue: got %b/%h exp 1/bfc00380", inst_req, inst_addr); else n_pass++;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'ha0a0_a0a0;
        #1;
        n_total++; if ({if_valid, if_inst} !== {1'b1, 32'ha0a0_a0a0}) $display("FAIL fr_done: got %b/%h exp 1/a0a0a0a0", if_valid, if_inst); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush_wait();
        pc_addr = 32'hbfc0_0010; inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; flush = 1'b1;
        #1;
        n_total++; if (if_valid !== 1'b0) $display("FAIL fw_flush_valid: got %b exp 0", if_valid); else n_pass++;
        @(negedge clk);
        flush = 1'b0; pc_addr = 32'hbfc0_0380; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        #1;
        n_total++; if ({if_valid, inst_req} !== 2'b00) $display("FAIL fw_discard: got %b%b exp 00", if_valid, inst_req); else n_pass++;
        @(negedge clk);
        inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc0_0380}) $display("FAIL fw_newpc: got %b/%h exp 1/bfc00380", inst_req, inst_addr); else n_pass++;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d_0000;
        #1;
        n_total++; if ({if_valid, if_inst} !== {1'b1, 32'h3c1d_0000}) $display("FAIL fw_done: got %b/%h exp 1/3c1d0000", if_valid, if_inst); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_misaligned();
        pc_addr = 32'hbfc0_0002; hold = 1'b1;
        #1;
        n_total++; if ({inst_req, if_valid, if_stall} !== 3'b001) $display("FAIL mis_hold: got %b%b%b exp 001", inst_req, if_valid, if_stall); else n_pass++;
        @(negedge clk);
        hold = 1'b0;
        #1;
        n_total++; if ({inst_req, if_valid, if_adel, if_stall} !== 4'b0110) $display("FAIL mis_done: got %b%b%b%b exp 0110", inst_req, if_valid, if_adel, if_stall); else n_pass++;
        n_total++; if (if_inst !== 32'h0) $display("FAIL mis_inst: got %h exp 0", if_inst); else n_pass++;
        @(negedge clk);
        pc_addr = 32'hbfc0_0004; inst_addr_ok = 1'b1;
        #1;
        n_total++; if ({inst_req, if_adel} !== 2'b10) $display("FAIL mis_next: got %b%b exp 10", inst_req, if_adel); else n_pass++;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0021;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_req();
        pc_addr = 32'hbfc0_0040;
        @(negedge clk);
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, 32'hbfc0_0040}) $display("FAIL rmr_req: got %b/%h exp 1/bfc00040", inst_req, inst_addr); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_total++; if ({inst_req, if_stall, if_valid} !== 3'b010) $display("FAIL rmr_in_rst: got %b%b%b exp 010", inst_req, if_stall, if_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0; pc_addr = RESET_VECTOR; inst_addr_ok = 1'b1;
        #1;
        n_total++; if ({inst_req, inst_addr} !== {1'b1, RESET_VECTOR}) $display("FAIL rmr_restart: got %b/%h exp 1/%h", inst_req, inst_addr, RESET_VECTOR); else n_pass++;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001;
        #1;
        n_total++; if ({if_valid, if_inst} !== {1'b1, 32'h2402_0001}) $display("FAIL rmr_done: got %b/%h exp 1/24020001", if_valid, if_inst); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    // Reference: a delivered instruction is always the word at the PC being held,
    // or an address error with zero data when that PC is misaligned.
    task automatic test_random();
        logic [31:0] pc_cur, pend_addr, bus_addr;
        logic        pend, busy, mis;
        int          cnt, ndel;
        rst = 1'b1;
        idle_inputs();
        pc_addr = RESET_VECTOR;
        repeat (2) @(negedge clk);
        pc_cur = RESET_VECTOR; pend_addr = 32'h0; bus_addr = 32'h0;
        pend = 1'b0; busy = 1'b0; cnt = 0; ndel = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst          = 1'b0;
            pc_addr      = pc_cur;
            hold         = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 24) == 0);
            inst_addr_ok = !busy && ($urandom_range(0, 2) != 0);
            inst_data_ok = busy && (cnt == 0);
            inst_rdata   = inst_data_ok ? mem_word(bus_addr) : $urandom();
            #1;
            mis = (pc_cur[1:0] != 2'b00);
            if (if_valid === 1'b1) begin
                ndel++;
                n_total++; if ({if_adel, if_inst} !== {mis, mis ? 32'h0 : mem_word(pc_cur)}) $display("FAIL rnd_deliver c%0d: got %b/%h exp %b/%h", cyc, if_adel, if_inst, mis, mis ? 32'h0 : mem_word(pc_cur)); else n_pass++;
                n_total++; if ({hold, flush} !== 2'b00) $display("FAIL rnd_valid_cond c%0d: valid with hold=%b flush=%b", cyc, hold, flush); else n_pass++;
            end
            n_total++; if (if_stall !== !if_valid) $display("FAIL rnd_stall c%0d: got %b exp %b", cyc, if_stall, !if_valid); else n_pass++;
            if (pend) begin
                n_total++; if ({inst_req, inst_addr} !== {1'b1, pend_addr}) $display("FAIL rnd_req_hold c%0d: got %b/%h exp 1/%h", cyc, inst_req, inst_addr, pend_addr); else n_pass++;
            end else if (inst_req === 1'b1) begin
                n_total++; if (inst_addr !== pc_cur || mis) $display("FAIL rnd_req_addr c%0d: got %h exp %h", cyc, inst_addr, pc_cur); else n_pass++;
            end
            pend      = inst_req && !inst_addr_ok;
            pend_addr = inst_addr;
            if (inst_data_ok) busy = 1'b0;
            else if (busy) cnt--;
            if (inst_req && inst_addr_ok) begin
                busy     = 1'b1;
                cnt      = $urandom_range(0, 2);
                bus_addr = inst_addr;
            end
            if (flush) pc_cur = {16'hbfc0, 14'($urandom()), 2'b00};
            else if (!if_stall) pc_cur = mis ? ({pc_cur[31:2], 2'b00} + 32'd4)
                                             : (($urandom_range(0, 9) == 0) ? pc_cur + 32'd6 : pc_cur + 32'd4);
        end
        n_total++; if (ndel < 200) $display("FAIL rnd_progress: got %0d deliveries exp >= 200", ndel); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_bus();
        test_hold();
        test_flush_req();
        test_flush_wait();
        test_misaligned();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
